// File: rtl/cpu_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 6502 control unit: FSM state encodings, opcode
// constants, internal-bus / address-mux select codes, ALU operation codes and
// the decoded-instruction record produced by cpu_opcode_decode.
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_OP1    = 4'd3,
        S_EXEC   = 4'd4,
        S_ADL    = 4'd5,
        S_ADH    = 4'd6,
        S_MEM    = 4'd7,
        S_BROFF  = 4'd8,
        S_BRTAKE = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_CLC  = 3'd1,
        CL_LDI  = 3'd2,   // load register immediate
        CL_ALUI = 3'd3,   // ALU op with immediate operand
        CL_ABS  = 3'd4,   // absolute load/store
        CL_BR   = 3'd5    // conditional relative branch
    } op_class_e;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_X = 2'd1,
        REG_Y = 2'd2
    } reg_e;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_CS = 2'd2,
        BR_CC = 2'd3
    } br_cond_e;

    typedef enum logic [3:0] {
        ALU_ADC = 4'd0,
        ALU_SBC = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORA = 4'd3,
        ALU_EOR = 4'd4
    } alu_op_e;

    // Opcodes of the supported subset
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_SBC_IMM = 8'hE9;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09;
    localparam logic [7:0] OP_EOR_IMM = 8'h49;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_LDX_ABS = 8'hAE;
    localparam logic [7:0] OP_LDY_ABS = 8'hAC;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_BCS     = 8'hB0;
    localparam logic [7:0] OP_BCC     = 8'h90;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    // Internal data bus sources (SELECT_DATA)
    localparam int         SD_W   = 3;
    localparam logic [2:0] SD_A   = 3'd0;
    localparam logic [2:0] SD_ALU = 3'd1;
    localparam logic [2:0] SD_IMM = 3'd2;
    localparam logic [2:0] SD_MDR = 3'd3;
    localparam logic [2:0] SD_X   = 3'd4;
    localparam logic [2:0] SD_Y   = 3'd5;

    // Address mux sources (SELECT_ADDRESS)
    localparam logic [1:0] SA_PC   = 2'd0;
    localparam logic [1:0] SA_MAR  = 2'd1;
    localparam logic [1:0] SA_CALC = 2'd2;

    typedef struct packed {
        op_class_e cls;
        reg_e      tgt;       // destination of loads, source of STA
        logic      is_store;
        alu_op_e   alu_op;
        br_cond_e  br;
        logic      legal;
    } dec_t;

    // ALU operations that consume the carry flag
    function automatic logic uses_carry(input alu_op_e op);
        return (op == ALU_ADC) || (op == ALU_SBC);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_if
// Bundle between the control FSM and the 6502 datapath.
//   master (control unit): reads DATA_IN and the flag outputs, drives every
//                          datapath strobe plus HALTED / STATE_DBG.
//   slave  (datapath):     the mirror image.
// -----------------------------------------------------------------------------
interface cpu_control_fsm_if;
    import cpu_pkg::*;

    logic [7:0]      DATA_IN;
    logic            OUT_CARRY_T, OUT_ZERO_T, OUT_NEGATIF_T, OUT_OVERFLOW_T;
    logic            reset_A, reset_X, reset_Y, reset_IMM, reset_MDR, reset_MAR, reset_PC;
    logic            reset_offset, reset_C, reset_Z, reset_N, reset_O, reset_I;
    logic            load_A, load_X, load_Y, load_IMM, load_MDR, load_MARL, load_MARH;
    logic            load_PC, load_offset;
    logic            SEL_A, SEL_X, SEL_Y, SEL_IMM, SEL_MDR;
    logic [SD_W-1:0] SELECT_DATA;
    logic [1:0]      SELECT_ADDRESS;
    logic            inc_PC, calcul_enable, alu_enable, enable_CARRY, set_Flag;
    logic            read_wire, write_wire;
    logic [3:0]      alu_opcode;
    logic            HALTED;
    logic [3:0]      STATE_DBG;

    modport master (
        input  DATA_IN, OUT_CARRY_T, OUT_ZERO_T, OUT_NEGATIF_T, OUT_OVERFLOW_T,
        output reset_A, reset_X, reset_Y, reset_IMM, reset_MDR, reset_MAR, reset_PC,
               reset_offset, reset_C, reset_Z, reset_N, reset_O, reset_I,
               load_A, load_X, load_Y, load_IMM, load_MDR, load_MARL, load_MARH,
               load_PC, load_offset, SEL_A, SEL_X, SEL_Y, SEL_IMM, SEL_MDR,
               SELECT_DATA, SELECT_ADDRESS, inc_PC, calcul_enable, alu_enable,
               enable_CARRY, set_Flag, read_wire, write_wire, alu_opcode,
               HALTED, STATE_DBG
    );

    modport slave (
        output DATA_IN, OUT_CARRY_T, OUT_ZERO_T, OUT_NEGATIF_T, OUT_OVERFLOW_T,
        input  reset_A, reset_X, reset_Y, reset_IMM, reset_MDR, reset_MAR, reset_PC,
               reset_offset, reset_C, reset_Z, reset_N, reset_O, reset_I,
               load_A, load_X, load_Y, load_IMM, load_MDR, load_MARL, load_MARH,
               load_PC, load_offset, SEL_A, SEL_X, SEL_Y, SEL_IMM, SEL_MDR,
               SELECT_DATA, SELECT_ADDRESS, inc_PC, calcul_enable, alu_enable,
               enable_CARRY, set_Flag, read_wire, write_wire, alu_opcode,
               HALTED, STATE_DBG
    );
endinterface

// File: rtl/cpu_control_fsm_decode.sv
// -----------------------------------------------------------------------------
// cpu_opcode_decode
// Purely combinational opcode classifier.
//   i_ir  : instruction register contents
//   o_dec : class, target register, store flag, ALU op, branch condition, legal
// -----------------------------------------------------------------------------
module cpu_opcode_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    output dec_t       o_dec
);

    // Opcode to instruction-class lookup; unknown opcodes are flagged illegal
    always_comb begin
        o_dec = '{cls: CL_NOP, tgt: REG_A, is_store: 1'b0, alu_op: ALU_ADC,
                  br: BR_EQ, legal: 1'b1};
        case (i_ir)
            OP_LDA_IMM: begin o_dec.cls = CL_LDI;  o_dec.tgt = REG_A; end
            OP_LDX_IMM: begin o_dec.cls = CL_LDI;  o_dec.tgt = REG_X; end
            OP_LDY_IMM: begin o_dec.cls = CL_LDI;  o_dec.tgt = REG_Y; end
            OP_ADC_IMM: begin o_dec.cls = CL_ALUI; o_dec.alu_op = ALU_ADC; end
            OP_SBC_IMM: begin o_dec.cls = CL_ALUI; o_dec.alu_op = ALU_SBC; end
            OP_AND_IMM: begin o_dec.cls = CL_ALUI; o_dec.alu_op = ALU_AND; end
            OP_ORA_IMM: begin o_dec.cls = CL_ALUI; o_dec.alu_op = ALU_ORA; end
            OP_EOR_IMM: begin o_dec.cls = CL_ALUI; o_dec.alu_op = ALU_EOR; end
            OP_LDA_ABS: begin o_dec.cls = CL_ABS;  o_dec.tgt = REG_A; end
            OP_LDX_ABS: begin o_dec.cls = CL_ABS;  o_dec.tgt = REG_X; end
            OP_LDY_ABS: begin o_dec.cls = CL_ABS;  o_dec.tgt = REG_Y; end
            OP_STA_ABS: begin o_dec.cls = CL_ABS;  o_dec.is_store = 1'b1; end
            OP_BEQ:     begin o_dec.cls = CL_BR;   o_dec.br = BR_EQ; end
            OP_BNE:     begin o_dec.cls = CL_BR;   o_dec.br = BR_NE; end
            OP_BCS:     begin o_dec.cls = CL_BR;   o_dec.br = BR_CS; end
            OP_BCC:     begin o_dec.cls = CL_BR;   o_dec.br = BR_CC; end
            OP_CLC:     o_dec.cls = CL_CLC;
            OP_NOP:     o_dec.cls = CL_NOP;
            default:    o_dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Fetch/decode/execute control unit for the 6502 datapath.
//   CLK   : rising-edge clock
//   RESET : synchronous, active-high; forces the reset strobe profile while high
//   ctrl  : master side of cpu_control_fsm_if (DATA_IN, flags in; strobes out)
// Strobes are a combinational function of (state, IR); while RESET is high they
// are overridden so a reset landing mid-instruction cannot fire a stray load.
// -----------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int RESET_CYCLES    = 2,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    cpu_control_fsm_if.master  ctrl
);

    localparam logic [7:0] CNT_LAST = 8'(RESET_CYCLES - 1);

    state_e     r_state, w_state_nxt;
    logic [7:0] r_ir, w_ir_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    dec_t       w_dec;
    logic       w_br_taken;
    logic       w_rst_all, w_rst_c;   // full datapath clear / carry-only clear
    logic       w_ld_mem;             // load target register from DATA_IN
    logic       w_ld_alu;             // load A from the ALU

    cpu_opcode_decode u_decode (
        .i_ir  (r_ir),
        .o_dec (w_dec)
    );

    // State register, instruction register and reset hold counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_RESET;
            r_ir    <= OP_NOP;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Branch condition sampled from the live flag outputs
    always_comb begin
        case (w_dec.br)
            BR_EQ:   w_br_taken = ctrl.OUT_ZERO_T;
            BR_NE:   w_br_taken = ~ctrl.OUT_ZERO_T;
            BR_CS:   w_br_taken = ctrl.OUT_CARRY_T;
            BR_CC:   w_br_taken = ~ctrl.OUT_CARRY_T;
            default: w_br_taken = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RESET: begin
                if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = ctrl.DATA_IN;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (!w_dec.legal) begin
                    w_state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    case (w_dec.cls)
                        CL_LDI, CL_ALUI: w_state_nxt = S_OP1;
                        CL_ABS:          w_state_nxt = S_ADL;
                        CL_BR:           w_state_nxt = S_BROFF;
                        default:         w_state_nxt = S_FETCH;
                    endcase
                end
            end
            S_OP1:    w_state_nxt = (w_dec.cls == CL_ALUI) ? S_EXEC : S_FETCH;
            S_EXEC:   w_state_nxt = S_FETCH;
            S_ADL:    w_state_nxt = S_ADH;
            S_ADH:    w_state_nxt = S_MEM;
            S_MEM:    w_state_nxt = S_FETCH;
            S_BROFF:  w_state_nxt = w_br_taken ? S_BRTAKE : S_FETCH;
            S_BRTAKE: w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_RESET;
        endcase
    end

    // Output decode: strobes per state, reset profile while RESET is high
    always_comb begin
        w_rst_all           = 1'b0;
        w_rst_c             = 1'b0;
        w_ld_mem            = 1'b0;
        w_ld_alu            = 1'b0;
        ctrl.load_IMM       = 1'b0;
        ctrl.load_MDR       = 1'b0;
        ctrl.load_MARL      = 1'b0;
        ctrl.load_MARH      = 1'b0;
        ctrl.load_PC        = 1'b0;
        ctrl.load_offset    = 1'b0;
        ctrl.SEL_IMM        = 1'b0;
        ctrl.SEL_MDR        = 1'b0;
        ctrl.SELECT_DATA    = SD_A;
        ctrl.SELECT_ADDRESS = SA_PC;
        ctrl.inc_PC         = 1'b0;
        ctrl.calcul_enable  = 1'b0;
        ctrl.alu_enable     = 1'b0;
        ctrl.enable_CARRY   = 1'b0;
        ctrl.set_Flag       = 1'b0;
        ctrl.read_wire      = 1'b0;
        ctrl.write_wire     = 1'b0;
        ctrl.alu_opcode     = ALU_ADC;
        if (RESET) begin
            w_rst_all = 1'b1;
        end else begin
            case (r_state)
                S_RESET:  w_rst_all = 1'b1;
                S_FETCH: begin
                    ctrl.read_wire = 1'b1;
                    ctrl.inc_PC    = 1'b1;
                end
                S_DECODE: w_rst_c = w_dec.legal && (w_dec.cls == CL_CLC);
                S_OP1: begin
                    ctrl.read_wire = 1'b1;
                    ctrl.inc_PC    = 1'b1;
                    if (w_dec.cls == CL_ALUI) begin
                        ctrl.SEL_IMM  = 1'b1;
                        ctrl.load_IMM = 1'b1;
                    end else begin
                        w_ld_mem = 1'b1;
                    end
                end
                S_EXEC: begin
                    ctrl.alu_enable   = 1'b1;
                    ctrl.alu_opcode   = w_dec.alu_op;
                    ctrl.enable_CARRY = uses_carry(w_dec.alu_op);
                    ctrl.SELECT_DATA  = SD_ALU;
                    ctrl.set_Flag     = 1'b1;
                    w_ld_alu          = 1'b1;
                end
                S_ADL, S_ADH: begin
                    ctrl.read_wire = 1'b1;
                    ctrl.inc_PC    = 1'b1;
                    ctrl.load_MARL = (r_state == S_ADL);
                    ctrl.load_MARH = (r_state == S_ADH);
                end
                S_MEM: begin
                    ctrl.SELECT_ADDRESS = SA_MAR;
                    if (w_dec.is_store) begin
                        ctrl.write_wire  = 1'b1;
                        ctrl.SELECT_DATA = SD_A;
                    end else begin
                        ctrl.read_wire = 1'b1;
                        w_ld_mem       = 1'b1;
                    end
                end
                S_BROFF: begin
                    ctrl.read_wire   = 1'b1;
                    ctrl.load_offset = 1'b1;
                    ctrl.inc_PC      = 1'b1;
                end
                // PC = address of next instruction + sign-extended offset
                S_BRTAKE: begin
                    ctrl.calcul_enable = 1'b1;
                    ctrl.load_PC       = 1'b1;
                end
                S_HALT:   w_rst_all = 1'b0;
                default:  w_rst_all = 1'b0;
            endcase
        end
    end

    assign ctrl.reset_A      = w_rst_all;
    assign ctrl.reset_X      = w_rst_all;
    assign ctrl.reset_Y      = w_rst_all;
    assign ctrl.reset_IMM    = w_rst_all;
    assign ctrl.reset_MDR    = w_rst_all;
    assign ctrl.reset_MAR    = w_rst_all;
    assign ctrl.reset_PC     = w_rst_all;
    assign ctrl.reset_offset = w_rst_all;
    assign ctrl.reset_C      = w_rst_all | w_rst_c;
    assign ctrl.reset_Z      = w_rst_all;
    assign ctrl.reset_N      = w_rst_all;
    assign ctrl.reset_O      = w_rst_all;
    assign ctrl.reset_I      = w_rst_all;

    assign ctrl.load_A = w_ld_alu | (w_ld_mem && (w_dec.tgt == REG_A));
    assign ctrl.load_X = w_ld_mem && (w_dec.tgt == REG_X);
    assign ctrl.load_Y = w_ld_mem && (w_dec.tgt == REG_Y);
    assign ctrl.SEL_A  = w_ld_mem && (w_dec.tgt == REG_A);
    assign ctrl.SEL_X  = w_ld_mem && (w_dec.tgt == REG_X);
    assign ctrl.SEL_Y  = w_ld_mem && (w_dec.tgt == REG_Y);

    assign ctrl.HALTED    = !RESET && (r_state == S_HALT);
    assign ctrl.STATE_DBG = RESET ? S_RESET : r_state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-cycle vector table (inputs + expected strobes)
// driven one cycle at a time; expected records go through a scoreboard queue
// and are compared against the DUT on the falling edge.
module tb_cpu_control_fsm;
    import cpu_pkg::*;

    typedef struct packed {
        logic        rst;
        logic [7:0]  din;
        logic        z;
        logic        c;
        logic [3:0]  st;
        logic [34:0] str;
        logic [2:0]  sd;
        logic [1:0]  sa;
        logic [3:0]  aop;
    } vec_t;

    // Strobe bit positions in the packed 35-bit strobe vector
    localparam logic [34:0] M_RST  = 35'h0_0000_1FFF;
    localparam logic [34:0] B_RC   = 35'd1 << 8;
    localparam logic [34:0] B_LA   = 35'd1 << 13;
    localparam logic [34:0] B_LX   = 35'd1 << 14;
    localparam logic [34:0] B_LY   = 35'd1 << 15;
    localparam logic [34:0] B_LIMM = 35'd1 << 16;
    localparam logic [34:0] B_LML  = 35'd1 << 18;
    localparam logic [34:0] B_LMH  = 35'd1 << 19;
    localparam logic [34:0] B_LPC  = 35'd1 << 20;
    localparam logic [34:0] B_LOFF = 35'd1 << 21;
    localparam logic [34:0] B_SA   = 35'd1 << 22;
    localparam logic [34:0] B_SX   = 35'd1 << 23;
    localparam logic [34:0] B_SY   = 35'd1 << 24;
    localparam logic [34:0] B_SIMM = 35'd1 << 25;
    localparam logic [34:0] B_INC  = 35'd1 << 27;
    localparam logic [34:0] B_CALC = 35'd1 << 28;
    localparam logic [34:0] B_ALU  = 35'd1 << 29;
    localparam logic [34:0] B_ENC  = 35'd1 << 30;
    localparam logic [34:0] B_SETF = 35'd1 << 31;
    localparam logic [34:0] B_RD   = 35'd1 << 32;
    localparam logic [34:0] B_WR   = 35'd1 << 33;
    localparam logic [34:0] B_HALT = 35'd1 << 34;
    localparam logic [34:0] RDINC  = B_RD | B_INC;
    localparam logic [34:0] EXEC_S = B_ALU | B_SETF | B_LA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_control_fsm_if bus ();

    cpu_control_fsm #(.RESET_CYCLES(2), .HALT_ON_ILLEGAL(1'b1)) dut (
        .CLK   (clk),
        .RESET (rst),
        .ctrl  (bus)
    );

    vec_t        vecs[$];
    logic [47:0] sb[$];
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [34:0] strobes();
        return {bus.HALTED, bus.write_wire, bus.read_wire, bus.set_Flag, bus.enable_CARRY,
                bus.alu_enable, bus.calcul_enable, bus.inc_PC,
                bus.SEL_MDR, bus.SEL_IMM, bus.SEL_Y, bus.SEL_X, bus.SEL_A,
                bus.load_offset, bus.load_PC, bus.load_MARH, bus.load_MARL, bus.load_MDR,
                bus.load_IMM, bus.load_Y, bus.load_X, bus.load_A,
                bus.reset_I, bus.reset_O, bus.reset_N, bus.reset_Z, bus.reset_C, bus.reset_offset,
                bus.reset_PC, bus.reset_MAR, bus.reset_MDR, bus.reset_IMM, bus.reset_Y,
                bus.reset_X, bus.reset_A};
    endfunction

    task automatic v(input logic r, input logic [7:0] d, input logic z, input logic c,
                     input logic [3:0] st, input logic [34:0] s, input logic [2:0] sd,
                     input logic [1:0] sa, input logic [3:0] aop);
        vecs.push_back('{r, d, z, c, st, s, sd, sa, aop});
    endtask

    task automatic p(input logic [7:0] d, input logic z, input logic c,
                     input logic [3:0] st, input logic [34:0] s);
        v(1'b0, d, z, c, st, s, SD_A, SA_PC, ALU_ADC);
    endtask

    // Fetch of an opcode followed by its decode cycle
    task automatic fd(input logic [7:0] op, input logic [34:0] dec_s);
        p(op, 1'b0, 1'b0, S_FETCH, RDINC);
        p(8'h00, 1'b0, 1'b0, S_DECODE, dec_s);
    endtask

    // One clock cycle: drive, push expectation, compare on the falling edge
    task automatic run(input vec_t e, input string tag);
        logic [47:0] act;
        logic [47:0] expv;
        rst                = e.rst;
        bus.DATA_IN        = e.din;
        bus.OUT_ZERO_T     = e.z;
        bus.OUT_CARRY_T    = e.c;
        bus.OUT_NEGATIF_T  = 1'($urandom);
        bus.OUT_OVERFLOW_T = 1'($urandom);
        sb.push_back({e.st, e.str, e.sd, e.sa, e.aop});
        @(negedge clk);
        act  = {bus.STATE_DBG, strobes(), bus.SELECT_DATA, bus.SELECT_ADDRESS, bus.alu_opcode};
        expv = sb.pop_front();
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got st=%0d str=%h sd=%0d sa=%0d aop=%0d, expected st=%0d str=%h sd=%0d sa=%0d aop=%0d",
                      tag, act[47:44], act[43:9], act[8:6], act[5:4], act[3:0],
                      expv[47:44], expv[43:9], expv[8:6], expv[5:4], expv[3:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic play(input string tag);
        for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("%s%0d", tag, i));
        vecs.delete();
    endtask

    initial begin
        // Reset: 3 cycles held, then RESET_CYCLES cycles of datapath clears
        for (int i = 0; i < 3; i++) v(1'b1, 8'h00, 1'b0, 1'b0, S_RESET, M_RST, SD_A, SA_PC, ALU_ADC);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        // LDA #42
        fd(8'hA9, 35'd0);
        p(8'h42, 1'b0, 1'b0, S_OP1, RDINC | B_LA | B_SA);
        // ADC #05
        fd(8'h69, 35'd0);
        p(8'h05, 1'b0, 1'b0, S_OP1, RDINC | B_LIMM | B_SIMM);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_EXEC, EXEC_S | B_ENC, SD_ALU, SA_PC, ALU_ADC);
        // STA $2000
        fd(8'h8D, 35'd0);
        p(8'h00, 1'b0, 1'b0, S_ADL, RDINC | B_LML);
        p(8'h20, 1'b0, 1'b0, S_ADH, RDINC | B_LMH);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_MEM, B_WR, SD_A, SA_MAR, ALU_ADC);
        // BEQ taken (Z=1), then not taken (Z=0)
        fd(8'hF0, 35'd0);
        p(8'hFC, 1'b1, 1'b0, S_BROFF, RDINC | B_LOFF);
        p(8'h00, 1'b0, 1'b0, S_BRTAKE, B_CALC | B_LPC);
        fd(8'hF0, 35'd0);
        p(8'hFC, 1'b0, 1'b0, S_BROFF, RDINC | B_LOFF);
        // CLC, NOP
        fd(8'h18, B_RC);
        fd(8'hEA, 35'd0);
        // LDX $1234
        fd(8'hAE, 35'd0);
        p(8'h34, 1'b0, 1'b0, S_ADL, RDINC | B_LML);
        p(8'h12, 1'b0, 1'b0, S_ADH, RDINC | B_LMH);
        v(1'b0, 8'h77, 1'b0, 1'b0, S_MEM, B_RD | B_LX | B_SX, SD_A, SA_MAR, ALU_ADC);
        // SBC / AND / ORA / EOR immediate
        fd(8'hE9, 35'd0);
        p(8'h01, 1'b0, 1'b0, S_OP1, RDINC | B_LIMM | B_SIMM);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_EXEC, EXEC_S | B_ENC, SD_ALU, SA_PC, ALU_SBC);
        fd(8'h29, 35'd0);
        p(8'h0F, 1'b0, 1'b0, S_OP1, RDINC | B_LIMM | B_SIMM);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_EXEC, EXEC_S, SD_ALU, SA_PC, ALU_AND);
        fd(8'h09, 35'd0);
        p(8'h0F, 1'b0, 1'b0, S_OP1, RDINC | B_LIMM | B_SIMM);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_EXEC, EXEC_S, SD_ALU, SA_PC, ALU_ORA);
        fd(8'h49, 35'd0);
        p(8'h0F, 1'b0, 1'b0, S_OP1, RDINC | B_LIMM | B_SIMM);
        v(1'b0, 8'h00, 1'b0, 1'b0, S_EXEC, EXEC_S, SD_ALU, SA_PC, ALU_EOR);
        // BCC taken (C=0), BCS not taken (C=0), BCS taken (C=1), BCC not taken (C=1)
        fd(8'h90, 35'd0);
        p(8'hFE, 1'b0, 1'b0, S_BROFF, RDINC | B_LOFF);
        p(8'h00, 1'b0, 1'b0, S_BRTAKE, B_CALC | B_LPC);
        fd(8'hB0, 35'd0);
        p(8'hFE, 1'b1, 1'b0, S_BROFF, RDINC | B_LOFF);
        fd(8'hB0, 35'd0);
        p(8'h04, 1'b0, 1'b1, S_BROFF, RDINC | B_LOFF);
        p(8'h00, 1'b0, 1'b0, S_BRTAKE, B_CALC | B_LPC);
        fd(8'h90, 35'd0);
        p(8'h04, 1'b0, 1'b1, S_BROFF, RDINC | B_LOFF);
        // LDX #, LDY #
        fd(8'hA2, 35'd0);
        p(8'h10, 1'b0, 1'b0, S_OP1, RDINC | B_LX | B_SX);
        fd(8'hA0, 35'd0);
        p(8'h11, 1'b0, 1'b0, S_OP1, RDINC | B_LY | B_SY);
        // LDA abs, LDY abs
        fd(8'hAD, 35'd0);
        p(8'h00, 1'b0, 1'b0, S_ADL, RDINC | B_LML);
        p(8'h30, 1'b0, 1'b0, S_ADH, RDINC | B_LMH);
        v(1'b0, 8'h5A, 1'b0, 1'b0, S_MEM, B_RD | B_LA | B_SA, SD_A, SA_MAR, ALU_ADC);
        fd(8'hAC, 35'd0);
        p(8'h01, 1'b0, 1'b0, S_ADL, RDINC | B_LML);
        p(8'h30, 1'b0, 1'b0, S_ADH, RDINC | B_LMH);
        v(1'b0, 8'hA5, 1'b0, 1'b0, S_MEM, B_RD | B_LY | B_SY, SD_A, SA_MAR, ALU_ADC);
        // BNE not taken (Z=1), then taken (Z=0)
        fd(8'hD0, 35'd0);
        p(8'h02, 1'b1, 1'b0, S_BROFF, RDINC | B_LOFF);
        fd(8'hD0, 35'd0);
        p(8'h02, 1'b0, 1'b0, S_BROFF, RDINC | B_LOFF);
        p(8'h00, 1'b0, 1'b0, S_BRTAKE, B_CALC | B_LPC);
        play("vec");

        // RESET during S_ADH: no MARH load that cycle, S_RESET afterwards
        fd(8'h8D, 35'd0);
        p(8'h00, 1'b0, 1'b0, S_ADL, RDINC | B_LML);
        v(1'b1, 8'h20, 1'b0, 1'b0, S_RESET, M_RST, SD_A, SA_PC, ALU_ADC);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        play("midrst");

        // Illegal opcode halts until RESET
        fd(8'hFF, 35'd0);
        for (int i = 0; i < 4; i++) p(8'hA9, 1'b1, 1'b1, S_HALT, B_HALT);
        v(1'b1, 8'h00, 1'b0, 1'b0, S_RESET, M_RST, SD_A, SA_PC, ALU_ADC);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        p(8'h00, 1'b0, 1'b0, S_RESET, M_RST);
        fd(8'hEA, 35'd0);
        play("halt");

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Control unit for the 6502 datapath. Each cycle it produces the full set of datapath control strobes: loads, resets, mux selects, ALU opcode and bus read/write.
- Fetches opcodes over DATA_IN, holds them in an internal instruction register (IR), and walks a fetch/decode/execute state machine for a defined instruction subset.
- Consumes the datapath flag outputs to resolve conditional branches.

Parameters:
- RESET_CYCLES, 2, number of cycles S_RESET holds all datapath resets after RESET deasserts (min 1).
- HALT_ON_ILLEGAL, 1, 1: an unknown opcode enters S_HALT; 0: it is executed as NOP.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  8  memory read data; valid combinationally in the cycle the address is driven.
- OUT_CARRY_T, OUT_ZERO_T, OUT_NEGATIF_T, OUT_OVERFLOW_T  input  1 each  datapath flag register outputs.
- reset_A, reset_X, reset_Y, reset_IMM, reset_MDR, reset_MAR, reset_PC, reset_offset, reset_C, reset_Z, reset_N, reset_O, reset_I  output  1 each  datapath clears.
- load_A, load_X, load_Y, load_IMM, load_MDR, load_MARL, load_MARH, load_PC, load_offset  output  1 each  register loads.
- SEL_A, SEL_X, SEL_Y, SEL_IMM, SEL_MDR  output  1 each  register input source; 1 = DATA_IN, 0 = internal bus.
- SELECT_DATA  output  3  internal data bus source (package constants).
- SELECT_ADDRESS  output  2  0 = PC, 1 = MAR, 2 = calculated address.
- inc_PC, calcul_enable, alu_enable, enable_CARRY, set_Flag, read_wire, write_wire  output  1 each.
- alu_opcode  output  4  ALU operation (package constants).
- HALTED  output  1  high while in S_HALT.
- STATE_DBG  output  4  current state encoding.

Behaviour:
- Outputs are a combinational function of (state, IR). Any output not listed for a state is 0. All outputs are 0 during RESET except all reset_* = 1.
- RESET=1 at a clock edge: state := S_RESET, IR := 0xEA, hold counter := 0. Takes priority over every transition, including mid-instruction.
- S_RESET: all reset_* = 1; stay until the counter reaches RESET_CYCLES, then go to S_FETCH.
- S_FETCH: SELECT_ADDRESS=0, read_wire, inc_PC; IR := DATA_IN; next S_DECODE.
- S_DECODE: no strobes; dispatch on IR:
  - immediate group → S_OP1
  - absolute group → S_ADL
  - branch → S_BROFF
  - CLC (18) → reset_C this cycle, then S_FETCH
  - NOP (EA) → S_FETCH
  - other → S_HALT, or S_FETCH if HALT_ON_ILLEGAL=0
- S_OP1: read_wire, SELECT_ADDRESS=0, inc_PC.
  - LDA# A9 / LDX# A2 / LDY# A0: SEL_r=1, load_r; next S_FETCH.
  - ADC# 69 / SBC# E9 / AND# 29 / ORA# 09 / EOR# 49: SEL_IMM=1, load_IMM; next S_EXEC.
- S_EXEC: alu_enable, alu_opcode per IR, enable_CARRY only for ADC/SBC, SELECT_DATA=ALU, SEL_A=0, load_A, set_Flag; next S_FETCH.
- S_ADL: SELECT_ADDRESS=0, read_wire, load_MARL, inc_PC; next S_ADH.
- S_ADH: same as S_ADL with load_MARH; next S_MEM.
- S_MEM: SELECT_ADDRESS=1; next S_FETCH.
  - LDA AD / LDX AE / LDY AC: read_wire, SEL_r=1, load_r.
  - STA 8D: write_wire, SELECT_DATA=A.
- S_BROFF: SELECT_ADDRESS=0, read_wire, load_offset, inc_PC.
  - Condition: BEQ F0 (Z=1), BNE D0 (Z=0), BCS B0 (C=1), BCC 90 (C=0).
  - Condition sampled from the flag inputs in this cycle.
  - Taken → S_BRTAKE; not taken → S_FETCH.
- S_BRTAKE: calcul_enable, load_PC. New PC = PC of the next instruction + sign-extended offset, 16-bit wrap; next S_FETCH.
- S_HALT: HALTED=1, no strobes; left only by RESET.
- Cycle counts: LDr# 3; ALU# 4; LDr/STA abs 5; branch 3 not taken, 4 taken; NOP/CLC 2.
- Loads do not modify flags; only S_EXEC asserts set_Flag.
- read_wire and write_wire are never asserted together. load_PC and inc_PC are never asserted together.

Decomposition:
- Package cpu_pkg holds:
  - state encodings
  - opcode constants
  - SELECT_DATA codes (A, ALU, IMM, MDR, X, Y)
  - SELECT_ADDRESS codes
  - alu_opcode codes
- One sub-module, cpu_opcode_decode: combinational IR → {class, target register, ALU op, branch condition, legal}.

Test Plan:
- RESET high 3 cycles, then low → all reset_* high for RESET_CYCLES cycles; first S_FETCH with SELECT_ADDRESS=0 and read_wire=1.
- Bytes A9 42 → load_A with SEL_A=1 in the 3rd cycle while DATA_IN=0x42; inc_PC asserted twice.
- Bytes 69 05 → S_EXEC asserts alu_enable, enable_CARRY, set_Flag, load_A; 4 cycles total.
- Bytes 8D 00 20 → load_MARL with DATA_IN=0x00, then load_MARH with 0x20; S_MEM drives write_wire=1, SELECT_ADDRESS=1, read_wire=0.
- F0 FC with Z=1 → S_BRTAKE (calcul_enable + load_PC); same bytes with Z=0 → S_FETCH after 3 cycles, no load_PC.
- Opcode 0xFF with HALT_ON_ILLEGAL=1 → HALTED=1 and stays high; RESET asserted in the middle of S_ADH → S_RESET on the next edge with no MAR load.
